speed_display_converter: RTL

SPEED_DISPLAY_CONVERTER -- requirements
Module: speed_display_converter

---
 rtl/speed_display_converter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/speed_display_converter.sv
// Signed velocity to four-digit seven-segment display converter.
// Multi-cycle double-dabble with fixed latency, registered active-low segment outputs.
module speed_display_converter #(
  parameter int WIDTH     = 10,
  parameter int SAT_VALUE = 999
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [WIDTH:0] i_value,
  input  logic           i_valid,
  output logic           o_ready,
  output logic           o_done,
  output logic [6:0]     o_seven_sign,
  output logic [6:0]     o_seven_hundred,
  output logic [6:0]     o_seven_ten,
  output logic [6:0]     o_seven_one
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, ENCODE} state_t;

  // WIDTH shifts convert at most WIDTH magnitude bits, so the clamp is also
  // bounded by 2^WIDTH-1; at default parameters this is just SAT_VALUE.
  localparam int MAG_MAX = (1 << WIDTH) - 1;
  localparam int SAT_EFF = (SAT_VALUE < MAG_MAX) ? SAT_VALUE : MAG_MAX;
  localparam logic [WIDTH:0] SAT_V    = (WIDTH+1)'(SAT_EFF);
  localparam logic [3:0]     CNT_INIT = 4'(WIDTH);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  state_t           state_q, state_d;
  logic [WIDTH:0]   value_q, value_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [6:0]       seg_sign_q, seg_sign_d;
  logic [6:0]       seg_hun_q, seg_hun_d;
  logic [6:0]       seg_ten_q, seg_ten_d;
  logic [6:0]       seg_one_q, seg_one_d;

  logic [WIDTH:0]   abs_v;
  logic [11:0]      adj;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Negation in WIDTH+1 bits keeps -2^WIDTH representable as an unsigned magnitude.
  assign abs_v = value_q[WIDTH] ? -value_q : value_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    seg_sign_d = seg_sign_q;
    seg_hun_d  = seg_hun_q;
    seg_ten_d  = seg_ten_q;
    seg_one_d  = seg_one_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          value_d = i_value;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sign_d  = value_q[WIDTH];
        mag_d   = (abs_v > SAT_V) ? SAT_V[WIDTH-1:0] : abs_v[WIDTH-1:0];
        bcd_d   = 12'd0;
        cnt_d   = CNT_INIT;
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d = {adj[10:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ENCODE;
      end
      ENCODE: begin
        seg_sign_d = (sign_q && (bcd_q != 12'd0)) ? SEG_MINUS : SEG_BLANK;
        seg_hun_d  = (bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd_q[11:8]);
        seg_ten_d  = (bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd_q[7:4]);
        seg_one_d  = seg7(bcd_q[3:0]);
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      value_q    <= '0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      seg_sign_q <= SEG_BLANK;
      seg_hun_q  <= SEG_BLANK;
      seg_ten_q  <= SEG_BLANK;
      seg_one_q  <= SEG_ZERO;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      seg_sign_q <= seg_sign_d;
      seg_hun_q  <= seg_hun_d;
      seg_ten_q  <= seg_ten_d;
      seg_one_q  <= seg_one_d;
    end
  end

  assign o_ready         = (state_q == IDLE);
  assign o_done          = done_q;
  assign o_seven_sign    = seg_sign_q;
  assign o_seven_hundred = seg_hun_q;
  assign o_seven_ten     = seg_ten_q;
  assign o_seven_one     = seg_one_q;

endmodule
